// File: rtl/usart_rx_if.sv
// rtl/usart_rx_if.sv - bus-side signal bundle for the USART receiver
interface usart_rx_if;
  logic       rx_pin;
  logic       read;
  logic       clear_errors;
  logic [7:0] data_out;
  logic       data_ready;
  logic       fifo_full;
  logic       framing_error;
  logic       overrun;

  modport master (
    output rx_pin, read, clear_errors,
    input  data_out, data_ready, fifo_full, framing_error, overrun
  );

  modport slave (
    input  rx_pin, read, clear_errors,
    output data_out, data_ready, fifo_full, framing_error, overrun
  );
endinterface

// File: rtl/usart_rx.sv
// rtl/usart_rx.sv - 8N1 serial receiver with mid-bit sampling and FWFT receive FIFO
module usart_rx #(
  parameter int CLOCKS_PER_BIT = 139,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic clk,
  input  logic reset,
  usart_rx_if.slave bus
);
  localparam int TW = $clog2(CLOCKS_PER_BIT);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [TW-1:0] TICK_FULL = TW'(CLOCKS_PER_BIT - 1);
  localparam logic [TW-1:0] TICK_HALF = TW'(CLOCKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] TICK_ONE  = TW'(1);
  localparam logic [AW:0]   PTR_ONE   = (AW+1)'(1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;

  state_t        state;
  logic          sync1, rxs, rxs_prev;
  logic [TW-1:0] tick;
  logic [2:0]    bitcnt;
  logic [7:0]    shreg;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW:0]   wptr, rptr;
  logic          err_frame, err_ovr;

  logic empty, full, pop, sample, push, frame_evt, ovr_evt;

  always_comb begin
    empty     = (wptr == rptr);
    full      = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    pop       = bus.read && !empty;
    sample    = (tick == '0);
    push      = (state == STOP) && sample && rxs;
    frame_evt = (state == STOP) && sample && !rxs;
    // A simultaneous pop frees the slot, so a push into a full FIFO is not an overrun.
    ovr_evt   = push && full && !pop;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      sync1     <= 1'b1;
      rxs       <= 1'b1;
      rxs_prev  <= 1'b1;
      tick      <= '0;
      bitcnt    <= '0;
      shreg     <= '0;
      wptr      <= '0;
      rptr      <= '0;
      err_frame <= 1'b0;
      err_ovr   <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      sync1    <= bus.rx_pin;
      rxs      <= sync1;
      rxs_prev <= rxs;

      case (state)
        IDLE: begin
          if (rxs_prev && !rxs) begin
            tick  <= TICK_HALF;
            state <= START;
          end
        end
        START: begin
          if (!sample) begin
            tick <= tick - TICK_ONE;
          end else if (rxs) begin
            state <= IDLE;
          end else begin
            tick   <= TICK_FULL;
            bitcnt <= '0;
            state  <= DATA;
          end
        end
        DATA: begin
          if (!sample) begin
            tick <= tick - TICK_ONE;
          end else begin
            shreg[bitcnt] <= rxs;
            tick          <= TICK_FULL;
            if (bitcnt == 3'd7) state <= STOP;
            else                bitcnt <= bitcnt + 3'd1;
          end
        end
        STOP: begin
          if (!sample) tick <= tick - TICK_ONE;
          else         state <= rxs ? IDLE : BRK;
        end
        BRK: begin
          if (rxs) state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if (push && (!full || pop)) begin
        mem[wptr[AW-1:0]] <= shreg;
        wptr              <= wptr + PTR_ONE;
      end
      if (pop) rptr <= rptr + PTR_ONE;

      err_frame <= (err_frame && !bus.clear_errors) || frame_evt;
      err_ovr   <= (err_ovr && !bus.clear_errors) || ovr_evt;
    end
  end

  assign bus.data_out      = mem[rptr[AW-1:0]];
  assign bus.data_ready    = !empty;
  assign bus.fifo_full     = full;
  assign bus.framing_error = err_frame;
  assign bus.overrun       = err_ovr;
endmodule

// File: tb/tb_usart_rx.sv
// tb/tb_usart_rx.sv - directed self-checking bench for usart_rx
module tb_usart_rx;
  localparam int C = 16;
  localparam int H = C / 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_pass = 0;
  int   n_total = 0;

  usart_rx_if bus();

  usart_rx #(.CLOCKS_PER_BIT(C), .FIFO_DEPTH(4)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Frame starts at the current negedge; stop sample lands 2+H cycles into the stop bit.
  task automatic send_frame(input logic [7:0] b, input int stop_low_bits,
                            input bit rd_at_stop, input bit chk_timing);
    bus.rx_pin = 1'b0;
    cycles(C);
    for (int k = 0; k < 8; k++) begin
      bus.rx_pin = b[k];
      cycles(C);
    end
    if (stop_low_bits > 0) begin
      bus.rx_pin = 1'b0;
      cycles(stop_low_bits * C);
    end else begin
      bus.rx_pin = 1'b1;
      for (int i = 0; i < C; i++) begin
        if (chk_timing && i == 2 + H)     check("ready_at_stop_sample", bus.data_ready, 1'b0);
        if (chk_timing && i == 2 + H + 1) check("ready_after_stop", bus.data_ready, 1'b1);
        bus.read = (rd_at_stop && i == 2 + H);
        @(negedge clk);
      end
      bus.read = 1'b0;
    end
  endtask

  task automatic pop_expect(input string tag, input logic [7:0] exp);
    check({tag, "_ready"}, bus.data_ready, 1'b1);
    check({tag, "_data"}, bus.data_out, exp);
    bus.read = 1'b1;
    @(negedge clk);
    bus.read = 1'b0;
  endtask

  initial begin
    bus.rx_pin = 1'b1;
    bus.read = 1'b0;
    bus.clear_errors = 1'b0;
    cycles(3);
    reset = 1'b0;
    check("rst_ready", bus.data_ready, 1'b0);
    check("rst_full", bus.fifo_full, 1'b0);
    check("rst_ferr", bus.framing_error, 1'b0);
    check("rst_ovr", bus.overrun, 1'b0);
    check("rst_data", bus.data_out, 8'h00);
    cycles(4);

    send_frame(8'hA5, 0, 1'b0, 1'b1);
    check("a5_data", bus.data_out, 8'hA5);
    check("a5_ferr", bus.framing_error, 1'b0);
    check("a5_ovr", bus.overrun, 1'b0);
    bus.read = 1'b1;
    @(negedge clk);
    bus.read = 1'b0;
    check("a5_popped", bus.data_ready, 1'b0);

    bus.rx_pin = 1'b0;
    cycles(4);
    bus.rx_pin = 1'b1;
    cycles(2 * C);
    check("glitch_ready", bus.data_ready, 1'b0);
    check("glitch_ferr", bus.framing_error, 1'b0);
    send_frame(8'h3C, 0, 1'b0, 1'b0);
    pop_expect("b3c", 8'h3C);
    check("b3c_empty", bus.data_ready, 1'b0);

    send_frame(8'h55, 2, 1'b0, 1'b0);
    check("brk_ferr", bus.framing_error, 1'b1);
    check("brk_ready", bus.data_ready, 1'b0);
    bus.rx_pin = 1'b1;
    cycles(C);
    send_frame(8'h0F, 0, 1'b0, 1'b0);
    check("b0f_ferr_sticky", bus.framing_error, 1'b1);
    pop_expect("b0f", 8'h0F);
    bus.clear_errors = 1'b1;
    @(negedge clk);
    bus.clear_errors = 1'b0;
    check("ferr_cleared", bus.framing_error, 1'b0);

    for (int v = 1; v <= 4; v++) send_frame(8'(v), 0, 1'b0, 1'b0);
    check("fill_full", bus.fifo_full, 1'b1);
    check("fill_no_ovr", bus.overrun, 1'b0);
    send_frame(8'h05, 0, 1'b0, 1'b0);
    check("ovr_set", bus.overrun, 1'b1);
    check("ovr_still_full", bus.fifo_full, 1'b1);
    for (int v = 1; v <= 4; v++) pop_expect("ovr_pop", 8'(v));
    check("ovr_drained", bus.data_ready, 1'b0);
    bus.clear_errors = 1'b1;
    @(negedge clk);
    bus.clear_errors = 1'b0;
    check("ovr_cleared", bus.overrun, 1'b0);

    for (int v = 1; v <= 4; v++) send_frame(8'(v), 0, 1'b0, 1'b0);
    send_frame(8'h06, 0, 1'b1, 1'b0);
    check("pp_no_ovr", bus.overrun, 1'b0);
    check("pp_full", bus.fifo_full, 1'b1);
    pop_expect("pp_head", 8'h02);
    pop_expect("pp_next", 8'h03);
    pop_expect("pp_next", 8'h04);
    check("pp_last_data", bus.data_out, 8'h06);
    check("pp_last_ready", bus.data_ready, 1'b1);

    bus.rx_pin = 1'b0;
    cycles(C);
    bus.rx_pin = 1'b1;
    cycles(3 * C + H);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid_rst_ready", bus.data_ready, 1'b0);
    check("mid_rst_full", bus.fifo_full, 1'b0);
    check("mid_rst_ferr", bus.framing_error, 1'b0);
    check("mid_rst_ovr", bus.overrun, 1'b0);
    check("mid_rst_data", bus.data_out, 8'h00);
    cycles(6 * C);
    check("mid_rst_idle", bus.data_ready, 1'b0);
    send_frame(8'h81, 0, 1'b0, 1'b0);
    check("b81_ferr", bus.framing_error, 1'b0);
    pop_expect("b81", 8'h81);
    check("b81_empty", bus.data_ready, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
